// File: rtl/log_normalizer.sv
// log_normalizer: finds the leading one of an unsigned integer by iterative
// left shift and returns a normalized mantissa x in [1,2) (x[0] is the
// integer bit) plus the exponent e, so that a ~= x * 2^e.
module log_normalizer #(
    parameter int W  = 16,
    parameter int n  = 8,
    parameter int EW = $clog2(W)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [W-1:0]  a,
    output logic [0:n]    x,
    output logic [EW-1:0] e,
    output logic          zero,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   r_q, r_d;
    logic [EW-1:0]  cnt_q, cnt_d;
    logic [0:n]     x_q, x_d;
    logic [EW-1:0]  e_q, e_d;
    logic           zero_q, zero_d;
    logic           done_q, done_d;

    // Next-state logic: accept in IDLE/DONE, shift until the MSB is set.
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        e_d     = e_q;
        zero_d  = zero_q;
        done_d  = done_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    if (a != '0) begin
                        r_d     = a;
                        cnt_d   = '0;
                        done_d  = 1'b0;
                        state_d = SHIFT;
                    end else begin
                        x_d     = '0;
                        e_d     = '0;
                        zero_d  = 1'b1;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            SHIFT: begin
                if (r_q[W-1]) begin
                    x_d     = r_q[W-1 -: n+1];
                    e_d     = EW'(W - 1) - cnt_q;
                    zero_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    r_d   = r_q << 1;
                    cnt_d = cnt_q + EW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and result registers; an active-low reset aborts immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            r_q     <= '0;
            cnt_q   <= '0;
            x_q     <= '0;
            e_q     <= '0;
            zero_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            e_q     <= e_d;
            zero_q  <= zero_d;
            done_q  <= done_d;
        end
    end

    assign x    = x_q;
    assign e    = e_q;
    assign zero = zero_q;
    assign done = done_q;
    assign busy = (state_q == SHIFT);

endmodule

// File: tb/tb_log_normalizer.sv
// tb_log_normalizer: randomized and directed checks of log_normalizer
// against an arithmetic reference model.
module tb_log_normalizer;

    localparam int W  = 16;
    localparam int N  = 8;
    localparam int EW = $clog2(W);

    logic          clk;
    logic          reset;
    logic          start;
    logic [W-1:0]  a;
    logic [0:N]    x;
    logic [EW-1:0] e;
    logic          zero;
    logic          busy;
    logic          done;

    int n_compared;
    int n_mismatch;

    log_normalizer #(.W(W), .n(N), .EW(EW)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .x     (x),
        .e     (e),
        .zero  (zero),
        .busy  (busy),
        .done  (done)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: exponent is floor(log2(a)), mantissa is a scaled so its
    // leading one lands at weight 2^n, truncated; latency counts the
    // accepting edge as cycle 1.
    task automatic model(input logic [W-1:0] av, output logic [0:N] ex,
                         output logic [EW-1:0] ee, output logic ez,
                         output int elat, output int ebusy);
        int p;
        longint scaled;
        if (av == 0) begin
            ex = '0; ee = '0; ez = 1'b1; elat = 1; ebusy = 0;
        end else begin
            p = 0;
            while ((longint'(av) >> (p + 1)) != 0) p++;
            scaled = (longint'(av) * (longint'(1) << (W - 1 - p))) >> (W - 1 - N);
            ex = (N+1)'(scaled);
            ee = EW'(p);
            ez = 1'b0;
            elat = 2 + (W - 1 - p);
            ebusy = 1 + (W - 1 - p);
        end
    endtask

    // Drives one start pulse and waits (bounded) for done.
    task automatic run_op(input logic [W-1:0] av, output int cycles,
                          output int busy_cycles, output int overlap);
        @(negedge clk);
        start = 1'b1;
        a = av;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = W'($urandom);
        cycles = 1;
        busy_cycles = 0;
        overlap = 0;
        while (!done && cycles < 3 * W) begin
            if (busy) busy_cycles++;
            @(posedge clk);
            #1;
            cycles++;
        end
        if (busy && done) overlap++;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b0;
        a = '0;
        #12;
        n_compared++;
        if ({x, e, zero, busy, done} !== '0) begin
            n_mismatch++;
            $display("[TB] FAIL reset_state: got x=%h e=%0d zero=%b busy=%b done=%b, need all 0",
                     x, e, zero, busy, done);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        n_compared++;
        if ({x, e, zero, busy, done} !== '0) begin
            n_mismatch++;
            $display("[TB] FAIL idle_after_reset: got x=%h e=%0d zero=%b busy=%b done=%b, need all 0",
                     x, e, zero, busy, done);
        end
    endtask

    task automatic test_vector(input logic [W-1:0] av, input string tag);
        logic [0:N]    ex;
        logic [EW-1:0] ee;
        logic          ez;
        int elat, ebusy, cyc, bc, ov;
        model(av, ex, ee, ez, elat, ebusy);
        run_op(av, cyc, bc, ov);
        n_compared++;
        if (cyc !== elat || bc !== ebusy || ov !== 0) begin
            n_mismatch++;
            $display("[TB] FAIL %s timing a=%h: got lat=%0d busy=%0d overlap=%0d, need lat=%0d busy=%0d overlap=0",
                     tag, av, cyc, bc, ov, elat, ebusy);
        end
        n_compared++;
        if (x !== ex || e !== ee || zero !== ez || done !== 1'b1) begin
            n_mismatch++;
            $display("[TB] FAIL %s result a=%h: got x=%h e=%0d zero=%b done=%b, need x=%h e=%0d zero=%b done=1",
                     tag, av, x, e, zero, done, ex, ee, ez);
        end
    endtask

    task automatic test_directed();
        test_vector(16'h8000, "msb_set");
        test_vector(16'h0001, "lsb_only");
        test_vector(16'h01B1, "val_433");
        n_compared++;
        if (x !== 9'b110110001 || e !== 4'd8) begin
            n_mismatch++;
            $display("[TB] FAIL val_433_const: got x=%b e=%0d, need x=110110001 e=8", x, e);
        end
        test_vector(16'h0000, "zero_in");
        test_vector(16'hFFFF, "all_ones");
    endtask

    task automatic test_random();
        logic [W-1:0] av;
        for (int i = 0; i < 40; i++) begin
            av = W'($urandom) >> $urandom_range(0, W);
            test_vector(av, "random");
        end
    endtask

    task automatic test_start_ignored_and_back_to_back();
        int cyc;
        @(negedge clk);
        start = 1'b1;
        a = 16'h0001;
        @(posedge clk);
        #1;
        cyc = 1;
        while (!done && cyc < 3 * W) begin
            @(negedge clk);
            start = ~start;
            a = 16'hFFFF;
            @(posedge clk);
            #1;
            cyc++;
        end
        start = 1'b0;
        n_compared++;
        if (cyc !== 17 || x !== 9'h100 || e !== 4'd0 || zero !== 1'b0) begin
            n_mismatch++;
            $display("[TB] FAIL start_in_shift: got lat=%0d x=%h e=%0d zero=%b, need lat=17 x=100 e=0 zero=0",
                     cyc, x, e, zero);
        end
        repeat (3) @(posedge clk);
        #1;
        n_compared++;
        if (done !== 1'b1 || x !== 9'h100 || busy !== 1'b0) begin
            n_mismatch++;
            $display("[TB] FAIL done_hold: got done=%b x=%h busy=%b, need done=1 x=100 busy=0", done, x, busy);
        end
        @(negedge clk);
        start = 1'b1;
        a = 16'hFFFF;
        @(posedge clk);
        #1;
        start = 1'b0;
        n_compared++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            n_mismatch++;
            $display("[TB] FAIL restart_from_done: got done=%b busy=%b, need done=0 busy=1", done, busy);
        end
        @(posedge clk);
        #1;
        n_compared++;
        if (done !== 1'b1 || x !== 9'h1FF || e !== 4'd15 || busy !== 1'b0) begin
            n_mismatch++;
            $display("[TB] FAIL restart_result: got done=%b x=%h e=%0d busy=%b, need done=1 x=1ff e=15 busy=0",
                     done, x, e, busy);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        start = 1'b1;
        a = 16'h0001;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        n_compared++;
        if ({x, e, zero, busy, done} !== '0) begin
            n_mismatch++;
            $display("[TB] FAIL async_reset: got x=%h e=%0d zero=%b busy=%b done=%b, need all 0",
                     x, e, zero, busy, done);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        n_compared++;
        if ({x, e, zero, busy, done} !== '0) begin
            n_mismatch++;
            $display("[TB] FAIL post_reset_quiet: got x=%h e=%0d zero=%b busy=%b done=%b, need all 0",
                     x, e, zero, busy, done);
        end
        test_vector(16'h0234, "after_reset");
    endtask

    // Runs every scenario in order, then prints the summary.
    initial begin
        n_compared = 0;
        n_mismatch = 0;
        test_reset();
        test_directed();
        test_random();
        test_start_ignored_and_back_to_back();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule

// File: doc/log_normalizer.md
Name: log_normalizer

Overview:
Upstream pre-stage for the logarithm unit. It takes an unsigned W-bit integer and finds its leading one by iterative left shift. It outputs the normalized mantissa x in [1,2) in the logarithm unit's [0:n] format (x[0] = integer bit) plus the integer exponent e, so that a ≈ x·2^e. Downstream, e becomes the integer part of log2(a) and x feeds the logarithm unit's x input.

Parameters:
W, 16, width of integer input a; must satisfy W >= n+1
n, 8, mantissa fraction bits; x is n+1 bits [0:n], same n as the logarithm unit
EW, $clog2(W), exponent width (holds 0..W-1)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  request; sampled on rising edge only in IDLE or DONE
a  input  W  unsigned integer operand; sampled on the accepting edge only
x  output  n+1 [0:n]  normalized mantissa; x[0]=1 unless zero=1
e  output  EW  exponent = bit position of leading one of a
zero  output  1  a was 0; x and e are 0
busy  output  1  high in SHIFT state
done  output  1  result valid; level, held until next accepted start

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; x=0, e=0, zero=0, busy=0, done=0; internal shift reg r=0, count cnt=0. Reset mid-operation aborts at once. No result is produced after release until a new start.
- States: IDLE, SHIFT, DONE.
- IDLE, start=1 at edge:
  - a!=0: r<=a, cnt<=0, go to SHIFT.
  - a==0: go to DONE with zero=1, x=0, e=0, done=1.
- SHIFT, each edge:
  - r[W-1]==1: go to DONE; x<=r[W-1 -: n+1] (truncation, no rounding; discarded low bits ignored), e<=W-1-cnt, zero<=0, done<=1.
  - r[W-1]==0: r<=r<<1, cnt<=cnt+1.
  - start is ignored in SHIFT. a may change freely after acceptance.
- DONE: x/e/zero/done held stable. start=1 behaves exactly as in IDLE, and done falls on that same edge (or stays 1 with new result if a==0). No other exit.
- busy=1 exactly while state=SHIFT. done and busy never both 1.
- Latency, counted from the accepting edge to the edge where done rises:
  - a==0: 1 cycle.
  - otherwise: 2 + lz cycles, where lz = leading zeros of a (0..W-1). Maximum W+1.
- Width rules:
  - cnt never exceeds W-1; cnt is EW bits wide.
  - e computed as W-1-cnt in EW bits, with no overflow.
  - x[0] is always 1 when zero=0.

Test Plan:
- a=16'h8000, start pulse -> done after 2 cycles, x=9'b100000000, e=15, zero=0, busy high for 1 cycle.
- a=16'h0001 -> done after 17 cycles, x=9'b100000000, e=0. busy high 16 cycles.
- a=16'h01B1 (433) -> done after 9 cycles, x=9'b110110001, e=8. Feed x to the logarithm unit and check its input matches.
- a=16'h0000 -> done after 1 cycle, zero=1, x=0, e=0, busy never asserted.
- Start a=16'h0001, toggle start and change a=16'hFFFF during SHIFT -> ignored; result x=9'h100, e=0. Then start in DONE with a=16'hFFFF -> done drops same edge, rises 2 cycles later with x=9'h1FF, e=15.
- Drive reset=0 asynchronously mid-SHIFT (between edges) -> x, e, zero, busy, done go 0 immediately. After release, outputs stay 0 with no start, and a fresh start gives a correct result.
